// File: rtl/sb_spram_256ka_pkg.sv
// Shared geometry for the 16K x 16 single-port RAM.
// Constants only; imported by the lane and top modules.
package sb_spram_256ka_pkg;

  localparam int SPRAM_DEPTH   = 16384;
  localparam int SPRAM_AWIDTH  = 14;
  localparam int SPRAM_DWIDTH  = 16;
  localparam int SPRAM_NIBBLES = 4;

endpackage

// File: rtl/sb_spram_256ka_nibble_lane.sv
// One 16384 x 4 storage lane with write enable and power clear.
// Ports: clk, pwr_n (async clear), we, addr, wdata, rdata (comb).
module spram_nibble_lane
  import sb_spram_256ka_pkg::*;
(
  input  logic                    clk,
  input  logic                    pwr_n,
  input  logic                    we,
  input  logic [SPRAM_AWIDTH-1:0] addr,
  input  logic [3:0]              wdata,
  output logic [3:0]              rdata
);

  // A cleared valid bit makes the word read as zero, so a power-off
  // wipes the whole lane at once without touching every array entry.
  logic [SPRAM_DEPTH-1:0] vld;
  logic [3:0]             mem [SPRAM_DEPTH];

  always_ff @(posedge clk or negedge pwr_n) begin
    if (!pwr_n) begin
      vld <= '0;
    end else if (we) begin
      vld[addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = vld[addr] ? mem[addr] : 4'h0;

endmodule

// File: rtl/sb_spram_256ka.sv
// 16K x 16 single-port RAM with nibble masks and power modes.
// Ports: clk, rst_n, address, datain, maskwren, wren, chipselect,
//        standby, sleep, poweroff (active-low power), dataout.
module sb_spram_256ka
  import sb_spram_256ka_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SPRAM_AWIDTH-1:0] address,
  input  logic [SPRAM_DWIDTH-1:0] datain,
  input  logic [SPRAM_NIBBLES-1:0] maskwren,
  input  logic                    wren,
  input  logic                    chipselect,
  input  logic                    standby,
  input  logic                    sleep,
  input  logic                    poweroff,
  output logic [SPRAM_DWIDTH-1:0] dataout
);

  logic                    access;
  logic                    rd;
  logic [SPRAM_DWIDTH-1:0] rdata;
  logic [SPRAM_DWIDTH-1:0] q;

  // Reset also blocks accesses so nothing lands while it is held.
  assign access = rst_n & chipselect & ~standby
                & ~sleep & poweroff;
  assign rd     = access & ~wren;

  for (genvar i = 0; i < SPRAM_NIBBLES; i++) begin : g_lane
    spram_nibble_lane u_lane (
      .clk   (clk),
      .pwr_n (poweroff),
      .we    (access & wren & maskwren[i]),
      .addr  (address),
      .wdata (datain[4*i +: 4]),
      .rdata (rdata[4*i +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!poweroff) begin
      q <= '0;
    end else if (rd) begin
      q <= rdata;
    end
  end

  // Sleep and power-off blank the output; q keeps the pre-sleep value.
  assign dataout = (poweroff & ~sleep) ? q : '0;

endmodule

// File: tb/tb_sb_spram_256ka.sv
// Directed table-driven bench for sb_spram_256ka.
// Vectors carry hand-computed expected DATAOUT after each edge.
module tb_sb_spram_256ka;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] address;
  logic [15:0] datain;
  logic [3:0]  maskwren;
  logic        wren;
  logic        chipselect;
  logic        standby;
  logic        sleep;
  logic        poweroff;
  logic [15:0] dataout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sb_spram_256ka dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .datain     (datain),
    .maskwren   (maskwren),
    .wren       (wren),
    .chipselect (chipselect),
    .standby    (standby),
    .sleep      (sleep),
    .poweroff   (poweroff),
    .dataout    (dataout)
  );

  typedef struct {
    string       name;
    logic [13:0] addr;
    logic [15:0] din;
    logic [3:0]  mask;
    logic        we;
    logic        cs;
    logic        stby;
    logic        slp;
    logic        pwr;
    logic [15:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [15:0] exp);
    checks++;
    if (dataout !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, dataout, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    address    = v.addr;
    datain     = v.din;
    maskwren   = v.mask;
    wren       = v.we;
    chipselect = v.cs;
    standby    = v.stby;
    sleep      = v.slp;
    poweroff   = v.pwr;
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check(v.name, v.exp);
  endtask

  function automatic vec_t mk(input string nm,
                              input logic [13:0] a,
                              input logic [15:0] d,
                              input logic [3:0] m,
                              input logic we, input logic cs,
                              input logic sb, input logic sl,
                              input logic pw,
                              input logic [15:0] e);
    vec_t v;
    v.name = nm; v.addr = a; v.din = d; v.mask = m;
    v.we = we; v.cs = cs; v.stby = sb; v.slp = sl;
    v.pwr = pw; v.exp = e;
    return v;
  endfunction

  initial begin
    vq.push_back(mk("wr_beef",   14'h1234, 16'hBEEF, 4'hF, 1,1,0,0,1, 16'h0000));
    vq.push_back(mk("rd_beef",   14'h1234, 16'h0000, 4'h0, 0,1,0,0,1, 16'hBEEF));
    vq.push_back(mk("wr_mask5",  14'h1234, 16'h0000, 4'h5, 1,1,0,0,1, 16'hBEEF));
    vq.push_back(mk("rd_b0e0",   14'h1234, 16'h0000, 4'h0, 0,1,0,0,1, 16'hB0E0));
    vq.push_back(mk("wr_mask0",  14'h1234, 16'h1111, 4'h0, 1,1,0,0,1, 16'hB0E0));
    vq.push_back(mk("rd_nochg",  14'h1234, 16'h0000, 4'h0, 0,1,0,0,1, 16'hB0E0));
    vq.push_back(mk("wr_aaaa",   14'h0000, 16'hAAAA, 4'hF, 1,1,0,0,1, 16'hB0E0));
    vq.push_back(mk("wr_5555",   14'h3FFF, 16'h5555, 4'hF, 1,1,0,0,1, 16'hB0E0));
    vq.push_back(mk("rd_lo",     14'h0000, 16'h0000, 4'h0, 0,1,0,0,1, 16'hAAAA));
    vq.push_back(mk("rd_hi",     14'h3FFF, 16'h0000, 4'h0, 0,1,0,0,1, 16'h5555));
    vq.push_back(mk("rd_lo2",    14'h0000, 16'h0000, 4'h0, 0,1,0,0,1, 16'hAAAA));
    vq.push_back(mk("cs0_hold",  14'h3FFF, 16'h0000, 4'h0, 0,0,0,0,1, 16'hAAAA));
    vq.push_back(mk("stby_hold", 14'h3FFF, 16'h0000, 4'h0, 0,1,1,0,1, 16'hAAAA));
    vq.push_back(mk("stby_wr",   14'h0000, 16'h1234, 4'hF, 1,1,1,0,1, 16'hAAAA));
    vq.push_back(mk("slp_rd",    14'h3FFF, 16'h0000, 4'h0, 0,1,0,1,1, 16'h0000));
    vq.push_back(mk("slp_wr",    14'h0000, 16'hFFFF, 4'hF, 1,1,1,1,1, 16'h0000));
    vq.push_back(mk("post_slp",  14'h3FFF, 16'h0000, 4'h0, 0,0,0,0,1, 16'hAAAA));
    vq.push_back(mk("rd_hi2",    14'h3FFF, 16'h0000, 4'h0, 0,1,0,0,1, 16'h5555));
    vq.push_back(mk("rd_kept",   14'h0000, 16'h0000, 4'h0, 0,1,0,0,1, 16'hAAAA));
    vq.push_back(mk("pwr_off",   14'h0000, 16'h0000, 4'h0, 0,1,0,1,0, 16'h0000));
    vq.push_back(mk("rd_clr_lo", 14'h0000, 16'h0000, 4'h0, 0,1,0,0,1, 16'h0000));
    vq.push_back(mk("rd_clr_hi", 14'h3FFF, 16'h0000, 4'h0, 0,1,0,0,1, 16'h0000));
    vq.push_back(mk("rd_clr_mid",14'h1234, 16'h0000, 4'h0, 0,1,0,0,1, 16'h0000));
    vq.push_back(mk("wr_nib0",   14'h0000, 16'hABCD, 4'h1, 1,1,0,0,1, 16'h0000));
    vq.push_back(mk("rd_nib0",   14'h0000, 16'h0000, 4'h0, 0,1,0,0,1, 16'h000D));

    rst_n = 1'b0;
    drive(mk("idle", 14'h0, 16'h0, 4'h0, 0,0,0,0,1, 16'h0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) step(vq[i]);

    // Write a value, then read it so DATAOUT holds 0x5555.
    step(mk("wr_0100", 14'h0100, 16'h5555, 4'hF, 1,1,0,0,1, 16'h000D));
    step(mk("rd_0100", 14'h0100, 16'h0000, 4'h0, 0,1,0,0,1, 16'h5555));

    // Sleep blanks the output without waiting for an edge.
    @(negedge clk);
    drive(mk("idle", 14'h0, 16'h0, 4'h0, 0,0,0,0,1, 16'h0));
    sleep = 1'b1;
    #1;
    check("slp_comb", 16'h0000);
    sleep = 1'b0;
    #1;
    check("slp_release", 16'h5555);

    // Reset mid-cycle clears at once; accesses during it are dropped.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 16'h0000);
    drive(mk("wr_rst", 14'h0200, 16'h7777, 4'hF, 1,1,0,0,1, 16'h0));
    @(posedge clk);
    #1;
    drive(mk("rd_rst", 14'h0100, 16'h0000, 4'h0, 0,1,0,0,1, 16'h0));
    @(posedge clk);
    #1;
    check("rst_rd_ign", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk("rd_0200", 14'h0200, 16'h0000, 4'h0, 0,1,0,0,1, 16'h0000));
    step(mk("rd_0100b",14'h0100, 16'h0000, 4'h0, 0,1,0,0,1, 16'h5555));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
